// File: rtl/packet_forward_tx.sv
// Serialises one forwarded packet (5-byte header + payload from byte memory) onto a valid/ready link.
// Optional trailing XOR checksum byte when PKT_TX_CHECKSUM_EN is defined.
module packet_forward_tx #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int ID_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ID_W-1:0]   MY_NODE_ID,
  input  logic [ID_W-1:0]   destinationID,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        pay_len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              busy,
  output logic              done
);

`ifdef PKT_TX_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_FETCH, S_SEND, S_CSUM, S_FIN} state_t;
  localparam state_t S_POST = S_CSUM;
  localparam logic   LAST_ON_DATA = 1'b0;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_FETCH, S_SEND, S_FIN} state_t;
  localparam state_t S_POST = S_FIN;
  localparam logic   LAST_ON_DATA = 1'b1;
`endif

  typedef struct packed {
    logic [ID_W-1:0]   dst;
    logic [ID_W-1:0]   src;
    logic [ADDR_W-1:0] base;
    logic [7:0]        len;
  } req_t;

  state_t            state, state_nx;
  req_t              req_q;
  logic [2:0]        hdr_idx;
  logic [7:0]        pay_idx;
  logic [DATA_W-1:0] pay_q;
  logic              first_q;
  logic [DATA_W-1:0] hdr_byte;
  logic              final_pay;
`ifdef PKT_TX_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;
`endif

  assign final_pay = (pay_idx == req_q.len - 8'd1);

  always_comb begin
    hdr_byte = '0;
    case (hdr_idx)
      3'd0:    hdr_byte = DATA_W'(req_q.dst[15:8]);
      3'd1:    hdr_byte = DATA_W'(req_q.dst[7:0]);
      3'd2:    hdr_byte = DATA_W'(req_q.src[15:8]);
      3'd3:    hdr_byte = DATA_W'(req_q.src[7:0]);
      default: hdr_byte = DATA_W'(req_q.len);
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    tx_data   = '0;
    tx_valid  = 1'b0;
    tx_last   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_HDR;
      S_HDR: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = hdr_byte;
        tx_last  = LAST_ON_DATA && hdr_idx == 3'd4 && req_q.len == 8'd0;
        if (tx_ready && hdr_idx == 3'd4)
          state_nx = (req_q.len == 8'd0) ? S_POST : S_FETCH;
      end
      S_FETCH: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        mem_addr  = req_q.base + ADDR_W'(pay_idx);
        state_nx  = S_SEND;
      end
      S_SEND: begin
        // Read data is only valid in the first SEND cycle; later stall cycles replay the copy.
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = first_q ? mem_rd_data : pay_q;
        tx_last  = LAST_ON_DATA && final_pay;
        if (tx_ready) state_nx = final_pay ? S_POST : S_FETCH;
      end
`ifdef PKT_TX_CHECKSUM_EN
      S_CSUM: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = csum_q;
        tx_last  = 1'b1;
        if (tx_ready) state_nx = S_FIN;
      end
`endif
      S_FIN: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_q   <= '0;
      hdr_idx <= '0;
      pay_idx <= '0;
      pay_q   <= '0;
      first_q <= 1'b0;
`ifdef PKT_TX_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      first_q <= (state == S_FETCH);
      if (state == S_SEND && first_q) pay_q <= mem_rd_data;
      case (state)
        S_IDLE: if (start) begin
          req_q   <= '{dst: destinationID, src: MY_NODE_ID, base: base_addr, len: pay_len};
          hdr_idx <= '0;
          pay_idx <= '0;
`ifdef PKT_TX_CHECKSUM_EN
          csum_q  <= '0;
`endif
        end
        S_HDR: if (tx_ready) begin
          hdr_idx <= hdr_idx + 3'd1;
`ifdef PKT_TX_CHECKSUM_EN
          csum_q  <= csum_q ^ tx_data;
`endif
        end
        S_SEND: if (tx_ready) begin
          pay_idx <= pay_idx + 8'd1;
`ifdef PKT_TX_CHECKSUM_EN
          csum_q  <= csum_q ^ tx_data;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_forward_tx.sv
// Directed bench for packet_forward_tx: scoreboard of expected link bytes, immediate-assertion checks.
module tb_packet_forward_tx;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int ID_W   = 16;
`ifdef PKT_TX_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ID_W-1:0]   MY_NODE_ID = '0;
  logic [ID_W-1:0]   destinationID = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [7:0]        pay_len = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rd_data = '0;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_last;
  logic              busy;
  logic              done;

  logic [7:0]        mem [0:1023];
  logic [8:0]        sb [$];
  logic [ADDR_W-1:0] addr_q [$];
  int                n_vec = 0, n_err = 0, done_cnt = 0, rd_cnt = 0;
  bit                ready_mode = 1'b0;

  packet_forward_tx #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clock(clock), .reset(reset), .start(start), .MY_NODE_ID(MY_NODE_ID),
    .destinationID(destinationID), .base_addr(base_addr), .pay_len(pay_len),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Synchronous-read memory; garbage on the bus when not reading.
  always @(posedge clock)
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    else           mem_rd_data <= 8'($urandom);

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clock); #1;
      tx_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pops on handshake, stall stability, done/read counting.
  initial begin
    bit         stalled = 1'b0;
    logic [8:0] held = '0;
    logic [8:0] exp_b;
    forever begin
      @(negedge clock);
      if (reset) stalled = 1'b0;
      else begin
        if (stalled) begin
          chk("stall_valid", tx_valid, 1);
          chk("stall_data", {tx_last, tx_data}, held);
        end
        if (tx_valid && tx_ready) begin
          chk("byte_expected", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            exp_b = sb.pop_front();
            chk("tx_byte", {tx_last, tx_data}, exp_b);
          end
        end
        stalled = tx_valid && !tx_ready;
        held    = {tx_last, tx_data};
        if (done) done_cnt++;
        if (mem_rd_en) begin
          rd_cnt++;
          addr_q.push_back(mem_addr);
        end
      end
    end
  end

  task automatic push_pkt(input logic [15:0] src, input logic [15:0] dst,
                          input logic [ADDR_W-1:0] base, input logic [7:0] len);
    logic [7:0] b [$];
    logic [7:0] x;
    logic [ADDR_W-1:0] a;
    b = {dst[15:8], dst[7:0], src[15:8], src[7:0], len};
    for (int i = 0; i < int'(len); i++) begin
      a = base + ADDR_W'(i);
      b.push_back(mem[a]);
    end
    if (CS != 0) begin
      x = '0;
      foreach (b[i]) x ^= b[i];
      b.push_back(x);
    end
    foreach (b[i]) sb.push_back({(i == b.size() - 1), b[i]});
  endtask

  task automatic send_pkt(input logic [15:0] src, input logic [15:0] dst,
                          input logic [ADDR_W-1:0] base, input logic [7:0] len);
    push_pkt(src, dst, base, len);
    @(posedge clock); #1;
    MY_NODE_ID = src; destinationID = dst; base_addr = base; pay_len = len; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    MY_NODE_ID = 16'($urandom); destinationID = 16'($urandom);
    base_addr = ADDR_W'($urandom); pay_len = 8'($urandom);
    chk("first_valid", tx_valid, 1);
    chk("busy_on_start", busy, 1);
  endtask

  task automatic wait_for_done(input string tag, output int n);
    bit got;
    got = 1'b0;
    n = 0;
    for (int k = 0; k < 4000 && !got; k++) begin
      @(negedge clock);
      n++;
      if (done) got = 1'b1;
    end
    chk({tag, "_done_seen"}, got, 1);
  endtask

  task automatic wait_done(input string tag, input int exp_cycles);
    int n;
    wait_for_done(tag, n);
    if (exp_cycles >= 0) chk({tag, "_cycles"}, n, exp_cycles);
    chk({tag, "_busy_fin"}, busy, 0);
    chk({tag, "_valid_fin"}, tx_valid, 0);
    @(negedge clock);
    chk({tag, "_done_1cyc"}, done, 0);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, tx_valid, 0);
    chk({tag, "_last"}, tx_last, 0);
    chk({tag, "_data"}, tx_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rden"}, mem_rd_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
  endtask

  initial begin
    int n;
    bit got;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33;

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk_quiet("reset");
    @(posedge clock); #1 reset = 1'b0;

    // Reference packet
    send_pkt(16'h0102, 16'h0A0B, 10'd4, 8'd3);
    wait_done("basic", 5 + 2 * 3 + 1 + CS);

    // Zero-length payload: no memory reads
    rd_cnt = 0;
    send_pkt(16'h0102, 16'h0A0B, 10'd4, 8'd0);
    wait_done("len0", 5 + 1 + CS);
    chk("len0_no_reads", rd_cnt, 0);

    // Random backpressure
    ready_mode = 1'b1;
    send_pkt(16'h5A5A, 16'hC3C3, 10'd100, 8'd10);
    wait_done("stall", -1);
    ready_mode = 1'b0;

    // Address wrap
    addr_q.delete();
    send_pkt(16'h0001, 16'h0002, 10'd1022, 8'd4);
    wait_done("wrap", 5 + 2 * 4 + 1 + CS);
    chk("wrap_nreads", addr_q.size(), 4);
    if (addr_q.size() == 4) begin
      chk("wrap_a0", addr_q[0], 1022);
      chk("wrap_a1", addr_q[1], 1023);
      chk("wrap_a2", addr_q[2], 0);
      chk("wrap_a3", addr_q[3], 1);
    end

    // Start while busy is ignored
    done_cnt = 0;
    send_pkt(16'h1111, 16'h2222, 10'd50, 8'd6);
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clock);
      if (mem_rd_en) got = 1'b1;
    end
    chk("busy_reached_payload", got, 1);
    @(posedge clock); #1 start = 1'b1; destinationID = 16'hDEAD; pay_len = 8'd9;
    @(posedge clock); #1 start = 1'b0;
    wait_done("busy_start", -1);
    repeat (8) @(negedge clock);
    chk("busy_start_done_cnt", done_cnt, 1);
    chk("busy_start_idle", busy, 0);

    // Start held through FIN is ignored there
    done_cnt = 0;
    push_pkt(16'h3333, 16'h4444, 10'd70, 8'd1);
    @(posedge clock); #1;
    MY_NODE_ID = 16'h3333; destinationID = 16'h4444; base_addr = 10'd70; pay_len = 8'd1;
    start = 1'b1;
    wait_for_done("fin_start", n);
    @(posedge clock); #1 start = 1'b0;
    repeat (6) @(negedge clock);
    chk("fin_start_done_cnt", done_cnt, 1);
    chk("fin_start_idle", busy, 0);
    chk("fin_start_sb", sb.size(), 0);

    // Reset mid-payload, then a fresh packet
    send_pkt(16'h7777, 16'h8888, 10'd300, 8'd8);
    repeat (9) @(negedge clock);
    chk("midrst_busy", busy, 1);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk_quiet("midrst");
    sb.delete();
    @(posedge clock); #1 reset = 1'b0;
    send_pkt(16'h9999, 16'hAAAA, 10'd500, 8'd2);
    wait_done("fresh", 5 + 2 * 2 + 1 + CS);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
